rtc_time_chain: RTL and testbench
=================================

// Module: rtc_time_chain
// PURPOSE
//  Parametrised sec/min/hour time-of-day chain with a day counter, a run/tick gate, a validated set handshake and 12/24 h display.
//  Successor to the fixed three-stage clock: cascaded modulus counters plus a range-checked atomic load path.
//  Sits between the prescaler, which supplies the 1 Hz tick, and the display/decoder logic.
// PARAMETERS
//  FIELD_W   6   width of each sec/min/hour field
//  SEC_MOD   60  seconds modulus (count 0..SEC_MOD-1)
//  MIN_MOD   60  minutes modulus
//  HOUR_MOD  24  hours modulus; 12 h display is defined only for HOUR_MOD==24
//  DAY_W     16  day counter width
// PORTS
//  clock      in  1        system clock; all logic on rising edge
//  reset      in  1        asynchronous, active-high reset
//  tick       in  1        one-cycle advance strobe (1 Hz from prescaler)
//  run        in  1        1 = tick advances time; 0 = hold
//  mode_12h   in  1        display mode select for disp_hour/pm
//  set_valid  in  1        set request
//  set_ready  out 1        chain can accept a set this cycle
//  set_sec    in  FIELD_W  load value, seconds
//  set_min    in  FIELD_W  load value, minutes
//  set_hour   in  FIELD_W  load value, hours (always 24 h encoding)
//  set_err    out 1        one-cycle pulse: set rejected (out of range)
//  count_sec  out FIELD_W  current seconds
//  count_min  out FIELD_W  current minutes
//  count_hour out FIELD_W  current hours, 0..HOUR_MOD-1
//  disp_hour  out FIELD_W  count_hour in 24 h mode; 1..12 in 12 h mode
//  pm         out 1        12 h mode: 1 when count_hour>=12; 24 h mode: 0
//  day_count  out DAY_W    days elapsed; wraps 2^DAY_W-1 -> 0
//  day_carry  out 1        one-cycle pulse on hour rollover
// BEHAVIOUR
//  - Reset: all counts 0, day_count 0, day_carry 0, set_err 0, set_ready 1.
//    Reset asserted mid-operation clears state immediately and drops any in-flight set.
//  - Advance: on a clock edge with tick&run&!accept, sec increments by 1.
//    sec SEC_MOD-1 -> 0 carries into min in the same edge; min MIN_MOD-1 -> 0 carries into hour.
//    hour HOUR_MOD-1 -> 0 increments day_count; day_carry is registered high for exactly that following cycle.
//    Example: 23:59:59 + tick -> 00:00:00, day+1, single edge.
//  - Set handshake: accept = set_valid & set_ready.
//    On accept with set_sec<SEC_MOD, set_min<MIN_MOD and set_hour<HOUR_MOD, all three fields load atomically at that edge. day_count is untouched.
//    If any field is out of range, time is unchanged and set_err pulses for the next cycle.
//    set_ready drops for exactly the one cycle after any accept (settle slot) and returns high after it.
//    A tick arriving in the settle slot advances normally.
//  - Simultaneous tick and accept: set wins and the tick is dropped; no carry or day_carry results.
//  - run=0: ticks are ignored; sets are still accepted.
//  - Display (combinational from count_hour): in 12 h mode, hour 0 -> 12 with pm=0, 12 -> 12 with pm=1, 13..23 -> 1..11 with pm=1.
//  - Width rule: every modulus must be <= 2^FIELD_W. Comparisons use full FIELD_W, so there are no silent truncations.
// CONFIGURATION
//  RTC_ALARM_EN defined:
//    Adds ports alarm_wr in 1, alarm_sec/min/hour in FIELD_W, alarm_on in 1, alarm_hit out 1.
//    alarm_wr latches the compare registers; reset clears them to 0.
//    alarm_hit is registered and pulses one cycle when a tick-advance lands exactly on the alarm time while alarm_on=1.
//    A set landing on the alarm time does not fire it.
//  RTC_ALARM_EN undefined: no alarm ports or registers exist.
// STRUCTURE
//  - Package rtc_pkg: default FIELD_W/SEC_MOD/MIN_MOD/HOUR_MOD/DAY_W constants, the noon constant 12, and the time_t struct {sec, min, hour}.
//  - Sub-module rtc_mod_counter (MOD, W): inc, load, load_val -> count, wrap.
//    It is instantiated three times, each stage's inc taken from the previous stage's wrap & inc.
//  - The top holds the set/validate logic, settle slot, day counter, display mapping and optional alarm.
// TESTING
//  1. Reset mid-count at 12:34:56, day 5 -> all outputs 0 on the next sample, set_ready=1.
//  2. Set 23:59:58, then 2 ticks with run=1 -> 23:59:59, then 00:00:00, day_count +1, day_carry high exactly 1 cycle.
//  3. Set sec=60 (min 10, hour 5) -> time unchanged, set_err pulse 1 cycle, set_ready low 1 cycle then high.
//  4. tick and valid set 08:00:00 in the same cycle -> 08:00:00 and no advance; next tick -> 08:00:01.
//  5. mode_12h=1: hour 0 -> disp 12 pm 0; hour 12 -> 12/1; hour 23 -> 11/1. run=0 with 5 ticks -> no change.
//  6. RTC_ALARM_EN: alarm 00:00:05 on, from 00:00:03 two ticks -> alarm_hit 1 cycle; set to 00:00:05 -> no hit.

Source files
------------

// File: rtl/rtc_pkg.sv
// rtc_pkg
//   Shared constants and types for the time-of-day chain.
//   - DEF_* : default field width, moduli and day-counter width
//   - NOON  : hour at which the 12 h display switches to pm
//   - time_t: {sec, min, hour} bundle at the default field width
package rtc_pkg;

  localparam int DEF_FIELD_W  = 6;
  localparam int DEF_SEC_MOD  = 60;
  localparam int DEF_MIN_MOD  = 60;
  localparam int DEF_HOUR_MOD = 24;
  localparam int DEF_DAY_W    = 16;
  localparam int NOON         = 12;

  typedef struct packed {
    logic [DEF_FIELD_W-1:0] sec;
    logic [DEF_FIELD_W-1:0] min;
    logic [DEF_FIELD_W-1:0] hour;
  } time_t;

endpackage

// File: rtl/rtc_mod_counter.sv
// rtc_mod_counter
//   One modulus-MOD stage of the time chain.
//   Ports:
//     clock, reset : rising-edge clock, asynchronous active-high reset
//     inc          : advance by one (wraps MOD-1 -> 0)
//     load         : load load_val (takes priority over inc)
//     load_val     : value to load, already range-checked by the caller
//     count        : current value, 0..MOD-1
//     wrap         : count is at its terminal value MOD-1; the next stage
//                    advances on (wrap & inc)
module rtc_mod_counter #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign wrap = (count == LAST);

  // NOTE: state is updated with non-blocking assignments so every stage
  // samples its neighbours' pre-edge values and the cascade resolves in one edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/rtc_time_chain.sv
// rtc_time_chain
//   sec/min/hour time-of-day chain with day counter, run/tick gate,
//   validated atomic set handshake and 12/24 h display mapping.
//   Optional alarm compare is built when RTC_ALARM_EN is defined.
//   Ports:
//     clock, reset          : rising-edge clock, async active-high reset
//     tick, run             : time advances on tick&run (unless a set is accepted)
//     mode_12h              : selects 12 h mapping for disp_hour/pm
//     set_valid/set_ready   : set handshake; ready drops one cycle after accept
//     set_sec/min/hour      : load values (hour in 24 h encoding)
//     set_err               : one-cycle pulse after an out-of-range set
//     count_sec/min/hour    : current time
//     disp_hour, pm         : display hour and pm flag
//     day_count, day_carry  : days elapsed; pulse after hour rollover
//     alarm_wr, alarm_sec/min/hour, alarm_on, alarm_hit : RTC_ALARM_EN only
module rtc_time_chain
  import rtc_pkg::*;
#(
  parameter int FIELD_W  = DEF_FIELD_W,
  parameter int SEC_MOD  = DEF_SEC_MOD,
  parameter int MIN_MOD  = DEF_MIN_MOD,
  parameter int HOUR_MOD = DEF_HOUR_MOD,
  parameter int DAY_W    = DEF_DAY_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               run,
  input  logic               mode_12h,
  input  logic               set_valid,
  output logic               set_ready,
  input  logic [FIELD_W-1:0] set_sec,
  input  logic [FIELD_W-1:0] set_min,
  input  logic [FIELD_W-1:0] set_hour,
  output logic               set_err,
  output logic [FIELD_W-1:0] count_sec,
  output logic [FIELD_W-1:0] count_min,
  output logic [FIELD_W-1:0] count_hour,
  output logic [FIELD_W-1:0] disp_hour,
  output logic               pm,
  output logic [DAY_W-1:0]   day_count,
`ifdef RTC_ALARM_EN
  input  logic               alarm_wr,
  input  logic [FIELD_W-1:0] alarm_sec,
  input  logic [FIELD_W-1:0] alarm_min,
  input  logic [FIELD_W-1:0] alarm_hour,
  input  logic               alarm_on,
  output logic               alarm_hit,
`endif
  output logic               day_carry
);

  // Limits carry one extra bit so a modulus of exactly 2^FIELD_W still
  // compares correctly against a full-width load value.
  localparam logic [FIELD_W:0]   SEC_LIM   = (FIELD_W+1)'(SEC_MOD);
  localparam logic [FIELD_W:0]   MIN_LIM   = (FIELD_W+1)'(MIN_MOD);
  localparam logic [FIELD_W:0]   HOUR_LIM  = (FIELD_W+1)'(HOUR_MOD);
  localparam logic [FIELD_W-1:0] NOON_F    = FIELD_W'(NOON);
  localparam bit                 HAS_12H   = (HOUR_MOD == 24);

  logic accept, in_range, load, advance;
  logic sec_wrap, min_wrap, hour_wrap;
  logic min_inc, hour_inc, day_inc;

  assign accept   = set_valid & set_ready;
  assign in_range = ({1'b0, set_sec}  < SEC_LIM) &
                    ({1'b0, set_min}  < MIN_LIM) &
                    ({1'b0, set_hour} < HOUR_LIM);
  assign load     = accept & in_range;
  // A set in the same cycle wins; the tick is dropped, not deferred.
  assign advance  = tick & run & ~accept;
  assign min_inc  = advance & sec_wrap;
  assign hour_inc = min_inc & min_wrap;
  assign day_inc  = hour_inc & hour_wrap;

  rtc_mod_counter #(.MOD(SEC_MOD), .W(FIELD_W)) u_sec (
    .clock    (clock),
    .reset    (reset),
    .inc      (advance),
    .load     (load),
    .load_val (set_sec),
    .count    (count_sec),
    .wrap     (sec_wrap)
  );

  rtc_mod_counter #(.MOD(MIN_MOD), .W(FIELD_W)) u_min (
    .clock    (clock),
    .reset    (reset),
    .inc      (min_inc),
    .load     (load),
    .load_val (set_min),
    .count    (count_min),
    .wrap     (min_wrap)
  );

  rtc_mod_counter #(.MOD(HOUR_MOD), .W(FIELD_W)) u_hour (
    .clock    (clock),
    .reset    (reset),
    .inc      (hour_inc),
    .load     (load),
    .load_val (set_hour),
    .count    (count_hour),
    .wrap     (hour_wrap)
  );

  // Handshake: ready low only in the settle slot right after an accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      set_ready <= 1'b1;
      set_err   <= 1'b0;
    end else begin
      set_ready <= ~accept;
      set_err   <= accept & ~in_range;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      day_count <= '0;
      day_carry <= 1'b0;
    end else begin
      day_carry <= day_inc;
      if (day_inc) day_count <= day_count + DAY_W'(1);
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    disp_hour = count_hour;
    pm        = 1'b0;
    if (HAS_12H && mode_12h) begin
      pm = (count_hour >= NOON_F);
      if (count_hour == '0)         disp_hour = NOON_F;
      else if (count_hour > NOON_F) disp_hour = count_hour - NOON_F;
    end
  end

`ifdef RTC_ALARM_EN
  logic [FIELD_W-1:0] alm_sec_q, alm_min_q, alm_hour_q;
  logic [FIELD_W-1:0] sec_nx, min_nx, hour_nx;

  // Time the chain will show after this edge if it advances.
  assign sec_nx  = sec_wrap ? '0 : count_sec + FIELD_W'(1);
  assign min_nx  = sec_wrap ? (min_wrap ? '0 : count_min + FIELD_W'(1)) : count_min;
  assign hour_nx = (sec_wrap & min_wrap) ?
                   (hour_wrap ? '0 : count_hour + FIELD_W'(1)) : count_hour;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alm_sec_q  <= '0;
      alm_min_q  <= '0;
      alm_hour_q <= '0;
      alarm_hit  <= 1'b0;
    end else begin
      if (alarm_wr) begin
        alm_sec_q  <= alarm_sec;
        alm_min_q  <= alarm_min;
        alm_hour_q <= alarm_hour;
      end
      // Only a tick-advance can fire; a set landing on the alarm cannot.
      alarm_hit <= advance & alarm_on & (sec_nx == alm_sec_q) &
                   (min_nx == alm_min_q) & (hour_nx == alm_hour_q);
    end
  end
`endif

endmodule

// File: tb/tb_rtc_time_chain.sv
// tb_rtc_time_chain
//   Self-checking bench for rtc_time_chain. The reference model keeps time
//   as a single seconds-of-day integer and a day number, and derives every
//   expected output from those with plain arithmetic.
module tb_rtc_time_chain;
  import rtc_pkg::*;

  localparam int DAY_SECS = 60 * 60 * 24;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, run = 1'b0, mode_12h = 1'b0, set_valid = 1'b0;
  logic [5:0] set_sec = '0, set_min = '0, set_hour = '0;
  logic       set_ready, set_err, pm, day_carry;
  logic [5:0] count_sec, count_min, count_hour, disp_hour;
  logic [15:0] day_count;
`ifdef RTC_ALARM_EN
  logic       alarm_wr = 1'b0, alarm_on = 1'b0, alarm_hit;
  logic [5:0] alarm_sec = '0, alarm_min = '0, alarm_hour = '0;
`endif

  always #5 clock = ~clock;

  rtc_time_chain dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .run        (run),
    .mode_12h   (mode_12h),
    .set_valid  (set_valid),
    .set_ready  (set_ready),
    .set_sec    (set_sec),
    .set_min    (set_min),
    .set_hour   (set_hour),
    .set_err    (set_err),
    .count_sec  (count_sec),
    .count_min  (count_min),
    .count_hour (count_hour),
    .disp_hour  (disp_hour),
    .pm         (pm),
    .day_count  (day_count),
`ifdef RTC_ALARM_EN
    .alarm_wr   (alarm_wr),
    .alarm_sec  (alarm_sec),
    .alarm_min  (alarm_min),
    .alarm_hour (alarm_hour),
    .alarm_on   (alarm_on),
    .alarm_hit  (alarm_hit),
`endif
    .day_carry  (day_carry)
  );

  // Reference model state
  int m_t, m_day;
  bit m_ready, m_err, m_carry;
`ifdef RTC_ALARM_EN
  int m_as, m_am, m_ah;
  bit m_hit;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_day = 0; m_ready = 1; m_err = 0; m_carry = 0;
`ifdef RTC_ALARM_EN
    m_as = 0; m_am = 0; m_ah = 0; m_hit = 0;
`endif
  endtask

  task automatic check_all(input string tag);
    int h, dh;
    h  = m_t / 3600;
    dh = (mode_12h) ? ((h % 12 == 0) ? 12 : h % 12) : h;
    check({tag, ".sec"},   32'(count_sec),  32'(m_t % 60));
    check({tag, ".min"},   32'(count_min),  32'((m_t / 60) % 60));
    check({tag, ".hour"},  32'(count_hour), 32'(h));
    check({tag, ".disp"},  32'(disp_hour),  32'(dh));
    check({tag, ".pm"},    32'(pm),         32'(mode_12h && h >= 12));
    check({tag, ".day"},   32'(day_count),  32'(m_day));
    check({tag, ".carry"}, 32'(day_carry),  32'(m_carry));
    check({tag, ".ready"}, 32'(set_ready),  32'(m_ready));
    check({tag, ".err"},   32'(set_err),    32'(m_err));
`ifdef RTC_ALARM_EN
    check({tag, ".hit"},   32'(alarm_hit),  32'(m_hit));
`endif
  endtask

  // Drive one cycle of inputs, let one rising edge pass, update the model, compare.
  task automatic step(input string tag, input bit t, input bit r, input bit v,
                      input int s, input int m, input int h);
    bit acc, adv;
    tick = t; run = r; set_valid = v;
    set_sec = 6'(s); set_min = 6'(m); set_hour = 6'(h);
    @(posedge clock);
    acc = v && m_ready;
    adv = t && r && !acc;
    m_err = acc && !(s < 60 && m < 60 && h < 24);
    if (acc && !m_err) m_t = h * 3600 + m * 60 + s;
    m_ready = !acc;
    m_carry = 0;
    if (adv) begin
      m_t++;
      if (m_t == DAY_SECS) begin
        m_t = 0;
        m_day = (m_day + 1) % 65536;
        m_carry = 1;
      end
    end
`ifdef RTC_ALARM_EN
    m_hit = adv && alarm_on && (m_t == m_ah * 3600 + m_am * 60 + m_as) &&
            m_as < 60 && m_am < 60;
    if (alarm_wr) begin
      m_as = int'(alarm_sec); m_am = int'(alarm_min); m_ah = int'(alarm_hour);
    end
`endif
    #1;
    check_all(tag);
  endtask

  initial begin
    int s, m, h;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clock);
    reset = 1'b0;

    // Build up day 5 and 12:34:56, then reset asynchronously mid-count.
    for (int i = 0; i < 5; i++) begin
      step("day_set", 0, 1, 1, 59, 59, 23);
      step("day_roll", 1, 1, 0, 0, 0, 0);
    end
    step("set_123456", 0, 1, 1, 56, 34, 12);
    step("count_run", 1, 1, 0, 0, 0, 0);
    check("day_before_reset", 32'(day_count), 32'd5);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("async_reset");
    @(negedge clock);
    reset = 1'b0;

    // 23:59:58 + two ticks -> midnight rollover with one-cycle day_carry.
    step("set_235958", 0, 1, 1, 58, 59, 23);
    step("tick_235959", 1, 1, 0, 0, 0, 0);
    step("tick_midnight", 1, 1, 0, 0, 0, 0);
    step("carry_drop", 0, 1, 0, 0, 0, 0);

    // Out-of-range set: time unchanged, err pulse, ready low one cycle.
    step("bad_sec", 0, 1, 1, 60, 10, 5);
    step("bad_after", 0, 1, 0, 0, 0, 0);
    step("bad_hour", 0, 1, 1, 0, 0, 24);
    step("bad_min", 0, 1, 1, 0, 63, 0);

    // Set and tick together: set wins; tick in the settle slot advances.
    step("idle", 0, 1, 0, 0, 0, 0);
    step("tick_and_set", 1, 1, 1, 0, 0, 8);
    step("settle_tick", 1, 1, 0, 0, 0, 0);
    step("valid_in_settle", 0, 1, 1, 30, 30, 3);

    // 12 h display and run=0 hold.
    mode_12h = 1'b1;
    step("h12_0", 0, 1, 1, 0, 0, 0);
    step("h12_gap", 0, 1, 0, 0, 0, 0);
    step("h12_12", 0, 1, 1, 0, 0, 12);
    step("h12_gap", 0, 1, 0, 0, 0, 0);
    step("h12_23", 0, 0, 1, 59, 59, 23);
    step("h12_gap", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("run0_hold", 1, 0, 0, 0, 0, 0);
    step("run0_set", 1, 0, 1, 1, 0, 11);
    mode_12h = 1'b0;
    step("h24_mode", 0, 1, 0, 0, 0, 0);

`ifdef RTC_ALARM_EN
    alarm_wr = 1'b1; alarm_sec = 6'd5; alarm_min = 6'd0; alarm_hour = 6'd0;
    alarm_on = 1'b1;
    step("alarm_wr", 0, 1, 1, 3, 0, 0);
    alarm_wr = 1'b0;
    step("alarm_t4", 1, 1, 0, 0, 0, 0);
    step("alarm_t5", 1, 1, 0, 0, 0, 0);
    step("alarm_after", 0, 1, 0, 0, 0, 0);
    step("alarm_set", 0, 1, 1, 5, 0, 0);
    step("alarm_set_after", 0, 1, 0, 0, 0, 0);
`endif

    // Randomised traffic, biased towards rollover boundaries.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) mode_12h = ~mode_12h;
      if ($urandom_range(0, 3) == 0) begin
        s = $urandom_range(55, 63);
        m = ($urandom_range(0, 1) == 1) ? 59 : int'($urandom_range(0, 63));
        h = ($urandom_range(0, 1) == 1) ? 23 : int'($urandom_range(0, 27));
      end else begin
        s = $urandom_range(0, 59); m = $urandom_range(0, 59); h = $urandom_range(0, 23);
      end
      step("random", 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0), s, m, h);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
